compuertas_param_seq: RTL and testbench

//  Parametrised, registered successor to the three-input/two-output gate block.
//  Two outputs S1/S2 each apply a runtime-selected 3-input logic function to WIDTH-bit operands A/B/C.

---
 rtl/compuertas_param_seq.sv | 171 +++++++++++++++++
 tb/tb_compuertas_param_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/compuertas_param_seq.sv
// Registered three-input gate block: two runtime-selected bitwise functions over WIDTH-bit
// operands, in direct mode (one result per in_valid) or as a self-driven truth-table sweep.
module compuertas_param_seq #(
    parameter int WIDTH = 4,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic [2:0]       op1,
    input  logic [2:0]       op2,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S1,
    output logic [WIDTH-1:0] S2,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sig
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DW_W-1:0]   dw_q, dw_d;
    logic [2:0]        op1_q, op1_d;
    logic [2:0]        op2_q, op2_d;
    logic [WIDTH-1:0]  s1_q, s1_d;
    logic [WIDTH-1:0]  s2_q, s2_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       sig_q, sig_d;

    logic [WIDTH-1:0]  sw_a, sw_b, sw_c;
    logic [WIDTH-1:0]  sw_f1, sw_f2;
    logic [WIDTH-1:0]  dir_f1, dir_f2;

    function automatic logic [WIDTH-1:0] gate_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a & b & c;
            3'd1: r = a | b | c;
            3'd2: r = a ^ b ^ c;
            3'd3: r = ~(a & b & c);
            3'd4: r = ~(a | b | c);
            3'd5: r = (a & b) | c;
            3'd6: r = (a & b) | (a & c) | (b & c);
            3'd7: r = (c & b) | (~c & a);
        endcase
        return r;
    endfunction

    // The sweep drives every operand bit from one bit of the combination index.
    assign sw_a = {WIDTH{cnt_q[2]}};
    assign sw_b = {WIDTH{cnt_q[1]}};
    assign sw_c = {WIDTH{cnt_q[0]}};

    assign sw_f1  = gate_f(op1_q, sw_a, sw_b, sw_c);
    assign sw_f2  = gate_f(op2_q, sw_a, sw_b, sw_c);
    assign dir_f1 = gate_f(op1, A, B, C);
    assign dir_f2 = gate_f(op2, A, B, C);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d     = state_q;
        cnt_d       = cnt_q;
        dw_d        = dw_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_valid_d = 1'b0;
        sig_d       = sig_q;

        unique case (state_q)
            ST_IDLE: begin
                // mode arbitrates a simultaneous start and in_valid.
                if (mode) begin
                    if (start) begin
                        state_d = ST_SWEEP;
                        op1_d   = op1;
                        op2_d   = op2;
                        sig_d   = '0;
                        cnt_d   = '0;
                        dw_d    = '0;
                    end
                end else if (in_valid) begin
                    s1_d        = dir_f1;
                    s2_d        = dir_f2;
                    out_valid_d = 1'b1;
                end
            end

            ST_SWEEP: begin
                if (dw_q == DW_LAST) begin
                    s1_d                = sw_f1;
                    s2_d                = sw_f2;
                    out_valid_d         = 1'b1;
                    sig_d[{1'b0, cnt_q}] = sw_f1[0];
                    sig_d[{1'b1, cnt_q}] = sw_f2[0];
                    dw_d                = '0;
                    cnt_d               = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    dw_d = dw_q + DW_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples
        // the values from before this edge, independent of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dw_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dw_q        <= dw_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            sig_q       <= sig_d;
        end
    end

    assign S1        = s1_q;
    assign S2        = s2_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_SWEEP);
    assign done      = (state_q == ST_DONE);
    assign sig       = sig_q;

endmodule

// File: tb/tb_compuertas_param_seq.sv
// Self-checking bench: two instances (DWELL=1 and DWELL=3) share stimulus and are compared
// every cycle against a per-bit truth-count reference model and hand-computed constants.
module tb_compuertas_param_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, mode, start, in_valid;
    logic [2:0]   op1, op2;
    logic [W-1:0] a, b, c;

    logic [W-1:0] s1 [2];
    logic [W-1:0] s2 [2];
    logic         ov [2];
    logic         busy [2];
    logic         done [2];
    logic [15:0]  sig [2];

    logic [W-1:0] m_s1 [2];
    logic [W-1:0] m_s2 [2];
    logic [15:0]  m_sig [2];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]   o1;
        logic [2:0]   o2;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vc;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    vec_t tbl [4];

    compuertas_param_seq #(.WIDTH(W), .DWELL(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .op1(op1), .op2(op2),
        .A(a), .B(b), .C(c), .in_valid(in_valid),
        .S1(s1[0]), .S2(s2[0]), .out_valid(ov[0]), .busy(busy[0]), .done(done[0]), .sig(sig[0])
    );

    compuertas_param_seq #(.WIDTH(W), .DWELL(3)) u_dut_d3 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .op1(op1), .op2(op2),
        .A(a), .B(b), .C(c), .in_valid(in_valid),
        .S1(s1[1]), .S2(s2[1]), .out_valid(ov[1]), .busy(busy[1]), .done(done[1]), .sig(sig[1])
    );

    always #5 clk = ~clk;

    function automatic int dwell_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference: each result bit depends only on how many of its three inputs are high.
    function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] r;
        int n;
        r = '0;
        for (int i = 0; i < W; i++) begin
            n = int'(x[i]) + int'(y[i]) + int'(z[i]);
            case (op)
                3'd0: r[i] = (n == 3);
                3'd1: r[i] = (n > 0);
                3'd2: r[i] = (n % 2 == 1);
                3'd3: r[i] = (n != 3);
                3'd4: r[i] = (n == 0);
                3'd5: r[i] = (x[i] && y[i]) || z[i];
                3'd6: r[i] = (n >= 2);
                3'd7: r[i] = z[i] ? y[i] : x[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dut(input int i, input string tag, input logic e_ov,
                             input logic e_busy, input logic e_done);
        check($sformatf("%s d%0d S1", tag, i), 32'(s1[i]), 32'(m_s1[i]));
        check($sformatf("%s d%0d S2", tag, i), 32'(s2[i]), 32'(m_s2[i]));
        check($sformatf("%s d%0d out_valid", tag, i), 32'(ov[i]), 32'(e_ov));
        check($sformatf("%s d%0d busy", tag, i), 32'(busy[i]), 32'(e_busy));
        check($sformatf("%s d%0d done", tag, i), 32'(done[i]), 32'(e_done));
        check($sformatf("%s d%0d sig", tag, i), 32'(sig[i]), 32'(m_sig[i]));
    endtask

    // One clock with both instances idle; only in_valid with mode=0 yields a result.
    task automatic direct_step(input string tag, input logic iv, input logic md, input logic st,
                               input logic [2:0] o1, input logic [2:0] o2,
                               input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] cv);
        in_valid = iv; mode = md; start = st;
        op1 = o1; op2 = o2; a = av; b = bv; c = cv;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (iv && !md) begin
                m_s1[i] = ref_gate(o1, av, bv, cv);
                m_s2[i] = ref_gate(o2, av, bv, cv);
            end
            check_dut(i, tag, iv && !md, 1'b0, 1'b0);
        end
    endtask

    // Starts a sweep and checks nper cycles after the accepting edge. poke injects a start
    // and a direct-mode in_valid while both instances are still busy.
    task automatic run_sweep(input string tag, input logic [2:0] o1, input logic [2:0] o2,
                             input int nper, input bit poke, input bit also_iv);
        logic [2:0]   cb;
        logic [W-1:0] ca, cbv, cc;
        int           d;
        logic         e_ov;
        mode = 1'b1; start = 1'b1; in_valid = also_iv;
        op1 = o1; op2 = o2;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) m_sig[i] = '0;
        for (int p = 1; p <= nper; p++) begin
            for (int i = 0; i < 2; i++) begin
                d = dwell_of(i);
                e_ov = (p >= d + 1) && (p <= 8 * d + 1) && ((p - 1) % d == 0);
                if (e_ov) begin
                    cb  = 3'((p - 1) / d - 1);
                    ca  = {W{cb[2]}};
                    cbv = {W{cb[1]}};
                    cc  = {W{cb[0]}};
                    m_s1[i] = ref_gate(o1, ca, cbv, cc);
                    m_s2[i] = ref_gate(o2, ca, cbv, cc);
                    m_sig[i][cb]     = m_s1[i][0];
                    m_sig[i][8 + cb] = m_s2[i][0];
                end
                check_dut(i, $sformatf("%s p%0d", tag, p), e_ov, p <= 8 * d, p == 8 * d + 1);
            end
            if (poke) begin
                start    = (p == 3);
                in_valid = (p == 6);
                mode     = (p == 6) ? 1'b0 : 1'b1;
                if (p == 3) begin
                    op1 = ~o1; op2 = ~o2;
                end
            end
            if (p < nper) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0; in_valid = 1'b0; mode = 1'b0;
    endtask

    initial begin
        tbl[0] = '{o1: 3'd2, o2: 3'd6, va: 4'b1100, vb: 4'b1010, vc: 4'b0110, e1: 4'b0000, e2: 4'b1110};
        tbl[1] = '{o1: 3'd7, o2: 3'd0, va: 4'b1100, vb: 4'b1010, vc: 4'b0110, e1: 4'b1010, e2: 4'b0000};
        tbl[2] = '{o1: 3'd1, o2: 3'd3, va: 4'b1100, vb: 4'b1010, vc: 4'b0110, e1: 4'b1110, e2: 4'b1111};
        tbl[3] = '{o1: 3'd4, o2: 3'd5, va: 4'b1100, vb: 4'b1010, vc: 4'b0110, e1: 4'b0001, e2: 4'b1110};

        rst = 1'b1; mode = 1'b0; start = 1'b0; in_valid = 1'b0;
        op1 = '0; op2 = '0; a = '0; b = '0; c = '0;
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = '0; m_s2[i] = '0; m_sig[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_dut(i, "reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table vectors: one result, then a quiet cycle proving a one-cycle pulse and hold.
        for (int r = 0; r < 4; r++) begin
            direct_step($sformatf("tbl%0d", r), 1'b1, 1'b0, 1'b0,
                        tbl[r].o1, tbl[r].o2, tbl[r].va, tbl[r].vb, tbl[r].vc);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("tbl%0d d%0d S1 const", r, i), 32'(s1[i]), 32'(tbl[r].e1));
                check($sformatf("tbl%0d d%0d S2 const", r, i), 32'(s2[i]), 32'(tbl[r].e2));
            end
            direct_step($sformatf("tbl%0d hold", r), 1'b0, 1'b0, 1'b0,
                        3'd0, 3'd0, 4'hF, 4'hF, 4'hF);
        end

        // Back-to-back strobes give a result every cycle.
        for (int k = 0; k < 3; k++) begin
            direct_step($sformatf("b2b%0d", k), 1'b1, 1'b0, 1'b0, 3'(k + 5), 3'(k),
                        W'($urandom), W'($urandom), W'($urandom));
        end

        // Randomized direct traffic, with start pulses that mode=0 must ignore.
        for (int k = 0; k < 40; k++) begin
            direct_step($sformatf("rnd%0d", k), 1'($urandom), 1'b0, 1'($urandom),
                        3'($urandom), 3'($urandom), W'($urandom), W'($urandom), W'($urandom));
        end

        // Sweeps: AND/XOR, then majority/OR with ignored start and in_valid while busy.
        run_sweep("sw_and_xor", 3'd0, 3'd2, 26, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) check($sformatf("sig9680 d%0d", i), 32'(sig[i]), 32'h9680);
        run_sweep("sw_maj_or", 3'd6, 3'd1, 26, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("sigFEE8 d%0d", i), 32'(sig[i]), 32'hFEE8);

        // Ignored inputs from IDLE: results and signature hold.
        direct_step("ign_iv0", 1'b1, 1'b1, 1'b0, 3'd1, 3'd4, 4'h3, 4'h5, 4'h9);
        direct_step("ign_iv1", 1'b1, 1'b1, 1'b0, 3'd2, 3'd3, 4'hA, 4'h1, 4'h7);
        direct_step("ign_st", 1'b0, 1'b0, 1'b1, 3'd5, 3'd6, 4'h2, 4'h4, 4'h8);
        direct_step("simul", 1'b1, 1'b0, 1'b1, 3'd5, 3'd6, 4'h2, 4'h4, 4'h8);

        // Reset mid-sweep: everything clears, no done pulse, then a clean sweep.
        run_sweep("sw_abort", 3'd3, 3'd7, 5, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = '0; m_s2[i] = '0; m_sig[i] = '0;
        end
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 2; i++) check_dut(i, $sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        run_sweep("sw_after_rst", 3'd0, 3'd2, 26, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("sig_rerun d%0d", i), 32'(sig[i]), 32'h9680);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
